// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and constants for the two-master Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam int NUM_MASTERS = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/wb_arb_rr.sv
// wb_arb_rr: round-robin pick between two requests, favouring the master that did not go last
module wb_arb_rr
  import wb_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   last,
  output logic [NUM_MASTERS-1:0] win
);
  always_comb win = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master round-robin Wishbone arbiter, one transfer per grant.
// Optional watchdog abort compiled in with WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADR_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADR_WIDTH-1:0]  m0_adr,
  input  logic [DATA_WIDTH-1:0] m0_wdat,
  input  logic                  m0_stb,
  input  logic                  m0_cyc,
  input  logic                  m0_we,
  output logic [DATA_WIDTH-1:0] m0_rdat,
  output logic                  m0_ack,
  input  logic [ADR_WIDTH-1:0]  m1_adr,
  input  logic [DATA_WIDTH-1:0] m1_wdat,
  input  logic                  m1_stb,
  input  logic                  m1_cyc,
  input  logic                  m1_we,
  output logic [DATA_WIDTH-1:0] m1_rdat,
  output logic                  m1_ack,
  output logic [ADR_WIDTH-1:0]  s_adr,
  output logic [DATA_WIDTH-1:0] s_wdat,
  output logic                  s_stb,
  output logic                  s_cyc,
  output logic                  s_we,
  input  logic [DATA_WIDTH-1:0] s_rdat,
  input  logic                  s_ack,
  output logic [1:0]            gnt,
  output logic                  tmo
);
  state_t state, state_nx;
  logic last, last_nx;
  logic [NUM_MASTERS-1:0] win;
  logic own, sel, stb, to, ack;
  logic [DATA_WIDTH-1:0] rdat;
  wb_arb_rr u_rr (.req({m1_stb, m0_stb}), .last(last), .win(win));
  assign own = state != IDLE;
  assign sel = state == OWN1;
  assign stb = own & (sel ? m1_stb : m0_stb);
`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= !own ? '0 : (s_ack ? cnt : cnt + 16'd1);
  assign to = stb & ~s_ack & (cnt == 16'(TIMEOUT_CYCLES));
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES[0];
  assign to = 1'b0;
`endif
  logic unused_cyc;
  assign unused_cyc = ^{m0_cyc, m1_cyc};
  assign ack  = stb & (s_ack | to);
  assign rdat = to ? '1 : s_rdat;
  assign tmo  = to;
  assign gnt  = {state == OWN1, state == OWN0};
  assign m0_ack  = ack & (state == OWN0);
  assign m1_ack  = ack & sel;
  assign m0_rdat = (state == OWN0) ? rdat : '0;
  assign m1_rdat = sel ? rdat : '0;
  assign s_stb  = stb & ~to;
  assign s_cyc  = stb & ~to;
  assign s_adr  = !own ? '0 : (sel ? m1_adr : m0_adr);
  assign s_wdat = !own ? '0 : (sel ? m1_wdat : m0_wdat);
  assign s_we   = own & (sel ? m1_we : m0_we);
  // An owned cycle ends on ack (real or watchdog) or when the owner drops stb
  always_comb begin
    state_nx = state;
    last_nx  = last;
    if (!own) state_nx = |win ? (win[1] ? OWN1 : OWN0) : IDLE;
    else if (ack | ~stb) begin
      state_nx = IDLE;
      last_nx  = sel;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed self-checking bench for wb_arbiter_2m (watchdog steps follow WB_ARB_TIMEOUT_EN)
module tb_wb_arbiter_2m;
  logic clk = 0, rst = 0;
  logic [31:0] m0_adr = 0, m1_adr = 0, s_adr;
  logic [7:0] m0_wdat = 0, m1_wdat = 0, m0_rdat, m1_rdat, s_wdat, s_rdat = 0;
  logic m0_stb = 0, m0_cyc = 0, m0_we = 0, m0_ack;
  logic m1_stb = 0, m1_cyc = 0, m1_we = 0, m1_ack;
  logic s_stb, s_cyc, s_we, s_ack = 0, tmo;
  logic [1:0] gnt;
  int checks = 0, failures = 0;
  logic [1:0] order [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  wb_arbiter_2m #(.DATA_WIDTH(8), .ADR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_adr(m0_adr), .m0_wdat(m0_wdat), .m0_stb(m0_stb), .m0_cyc(m0_cyc), .m0_we(m0_we),
    .m0_rdat(m0_rdat), .m0_ack(m0_ack),
    .m1_adr(m1_adr), .m1_wdat(m1_wdat), .m1_stb(m1_stb), .m1_cyc(m1_cyc), .m1_we(m1_we),
    .m1_rdat(m1_rdat), .m1_ack(m1_ack),
    .s_adr(s_adr), .s_wdat(s_wdat), .s_stb(s_stb), .s_cyc(s_cyc), .s_we(s_we),
    .s_rdat(s_rdat), .s_ack(s_ack), .gnt(gnt), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 chk("rst_gnt", gnt, 0);
    chk("rst_sstb", s_stb, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_tmo", tmo, 0);
    rst = 1;
    // single master write
    @(negedge clk);
    m0_adr = 32'h4; m0_wdat = 8'hA5; m0_we = 1; m0_stb = 1; s_ack = 1;
    #1 chk("idle_sack_ignored", m0_ack, 0);
    chk("pre_grant_sstb", s_stb, 0);
    #1 s_ack = 0;
    @(negedge clk);
    #1 chk("w_sstb", s_stb, 1);
    chk("w_gnt", gnt, 2'b01);
    chk("w_swe", s_we, 1);
    chk("w_sadr", s_adr, 32'h4);
    chk("w_swdat", s_wdat, 8'hA5);
    chk("w_noack_yet", m0_ack, 0);
    @(negedge clk);
    s_ack = 1;
    #1 chk("w_ack", m0_ack, 1);
    @(negedge clk);
    m0_stb = 0; m0_we = 0; s_ack = 0;
    #1 chk("w_gnt_idle", gnt, 0);
    chk("w_sstb_idle", s_stb, 0);
    chk("w_ack_once", m0_ack, 0);
    // tie after reset
    #1 rst = 0;
    #1 rst = 1;
    @(negedge clk);
    m0_stb = 1; m1_stb = 1; m1_adr = 32'h8;
    @(negedge clk);
    #1 chk("tie_first", gnt, 2'b01);
    chk("tie_sadr0", s_adr, 32'h4);
    s_ack = 1;
    #1 chk("tie_m0_ack", m0_ack, 1);
    chk("tie_m1_noack", m1_ack, 0);
    @(negedge clk);
    m0_stb = 0; s_ack = 0;
    #1 chk("tie_gap", gnt, 0);
    // read by master 1
    @(negedge clk);
    #1 chk("tie_second", gnt, 2'b10);
    chk("rd_sadr1", s_adr, 32'h8);
    chk("rd_swe", s_we, 0);
    s_rdat = 8'h3C; s_ack = 1;
    #1 chk("rd_m1_ack", m1_ack, 1);
    chk("rd_m1_rdat", m1_rdat, 8'h3C);
    chk("rd_m0_rdat", m0_rdat, 0);
    chk("rd_m0_ack", m0_ack, 0);
    @(negedge clk);
    m1_stb = 0; s_ack = 0; s_rdat = 0;
    // fairness under continuous contention
    m0_stb = 1; m1_stb = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 chk($sformatf("fair_gnt%0d", k), gnt, order[k]);
      s_ack = 1;
      @(negedge clk);
      s_ack = 0;
      #1 chk($sformatf("fair_gap%0d", k), gnt, 0);
    end
    m1_stb = 0;
    // master 0 goes last, then reset during master 1's ownership
    @(negedge clk);
    #1 chk("pre_rst_m0", gnt, 2'b01);
    s_ack = 1;
    @(negedge clk);
    s_ack = 0; m0_stb = 0; m1_stb = 1;
    @(negedge clk);
    #1 chk("pre_rst_own1", gnt, 2'b10);
    chk("pre_rst_sstb", s_stb, 1);
    s_ack = 1;
    #1 rst = 0;
    #1 chk("mid_rst_sstb", s_stb, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_m1ack", m1_ack, 0);
    @(negedge clk);
    rst = 1; s_ack = 0; m0_stb = 1; m1_stb = 1;
    @(negedge clk);
    #1 chk("post_rst_tie", gnt, 2'b01);
`ifdef WB_ARB_TIMEOUT_EN
    repeat (3) @(negedge clk);
    #1 chk("wd_before_limit", tmo, 0);
    chk("wd_before_ack", m0_ack, 0);
    @(negedge clk);
    #1 chk("wd_ack", m0_ack, 1);
    chk("wd_rdat", m0_rdat, 8'hFF);
    chk("wd_tmo", tmo, 1);
    chk("wd_sstb", s_stb, 0);
    m0_stb = 0; m1_stb = 0;
    @(negedge clk);
    #1 chk("wd_idle", gnt, 0);
    chk("wd_tmo_pulse", tmo, 0);
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1 chk($sformatf("nowd_sstb%0d", k), s_stb, 1);
    end
    chk("nowd_noack", m0_ack, 0);
    chk("nowd_tmo", tmo, 0);
    m0_stb = 0; m1_stb = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
